// File: rtl/pic_inta_sequencer_pkg.sv
// Shared types and constants for the 8259 INTA sequencer.
package pic_pkg;

    localparam int VEC_W              = 8;
    localparam int CNT_W              = 4;
    localparam int PULSE_CYCLES_DEF   = 2;
    localparam int GAP_CYCLES_DEF     = 2;
    localparam int RECOVER_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1      = 3'd1,
        GAP     = 3'd2,
        P2      = 3'd3,
        HOLD    = 3'd4,
        RECOVER = 3'd5
    } inta_state_t;

    // Timed states count N-1 down to zero, so they last exactly N cycles.
    function automatic logic [CNT_W-1:0] cnt_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// PIC-side INTA/data bus plus host-side vector valid/ready handshake.
interface pic_inta_sequencer_if;
    import pic_pkg::*;

    logic             inta_n;
    logic [VEC_W-1:0] data_bus;
    logic [VEC_W-1:0] vec_data;
    logic             vec_valid;
    logic             vec_ready;

    modport master (
        output inta_n, vec_data, vec_valid,
        input  data_bus, vec_ready
    );

    modport slave (
        input  inta_n, vec_data, vec_valid,
        output data_bus, vec_ready
    );

endinterface

// File: rtl/pic_inta_sequencer_sync_2ff.sv
// Generic single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pic_inta_sequencer.sv
// Two-pulse INTA generator for a cascaded 8259 chain; captures the vector and
// hands it to the host over valid/ready.
//
// state   | meaning
// IDLE    | waiting for synchronized INT with enable
// P1      | first INTA low pulse (PIC freezes ISR/priority)
// GAP     | INTA high between pulses
// P2      | second INTA low pulse, PIC drives vector
// HOLD    | vector presented, waiting for vec_ready
// RECOVER | quiet time, INT ignored, lets INT drop or EOI land
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_CYCLES   = PULSE_CYCLES_DEF,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 int_req_i,
    input  logic                 enable_i,
    pic_inta_sequencer_if.master bus,
    output logic                 busy_o,
    output logic [7:0]           vec_count_o
);

    logic             int_s;
    inta_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_zero;
    logic             capture;
    logic             inta_n_q;
    logic             vec_valid_q;
    logic [VEC_W-1:0] vec_data_q;
    logic [7:0]       vec_count_q;

    sync_2ff u_int_sync (
        .clk (clk),
        .rst (rst),
        .d_i (int_req_i),
        .q_o (int_s)
    );

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (int_s && enable_i) begin
                    state_d = P1;
                    cnt_d   = cnt_load(PULSE_CYCLES);
                end
            end
            P1: begin
                if (cnt_zero) begin
                    state_d = GAP;
                    cnt_d   = cnt_load(GAP_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = P2;
                    cnt_d   = cnt_load(PULSE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            P2: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.vec_ready) begin
                    state_d = RECOVER;
                    cnt_d   = cnt_load(RECOVER_CYCLES);
                end
            end
            RECOVER: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign capture = (state_q == P2) && (state_d == HOLD);

    // Outputs are registered from state_d so INTA never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            inta_n_q    <= 1'b1;
            vec_valid_q <= 1'b0;
            vec_data_q  <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inta_n_q    <= !((state_d == P1) || (state_d == P2));
            vec_valid_q <= (state_d == HOLD);
            if (capture) begin
                vec_data_q  <= bus.data_bus;
                vec_count_q <= vec_count_q + 8'd1;
            end
        end
    end

    assign bus.inta_n    = inta_n_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.vec_data  = vec_data_q;
    assign busy_o        = (state_q != IDLE);
    assign vec_count_o   = vec_count_q;

endmodule
